// File: rtl/tone_pkg.sv
// ============================================================================
// Module      : tone_pkg
// Description : Shared widths, pipeline latency and quadrant type for tone_nco.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tone_pkg;

    localparam int BITSIZE_DEF = 16;
    localparam int PHASE_W_DEF = 24;
    localparam int LUT_AW_DEF  = 8;

    // tick cycle to sample_valid, in clk cycles
    localparam int TICK_LAT    = 4;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

endpackage

`default_nettype wire

// File: rtl/sine_quarter_rom.sv
// ============================================================================
// Module      : sine_quarter_rom
// Description : Quarter-wave sine table with a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sine_quarter_rom
    import tone_pkg::*;
#(
    parameter int LUT_AW  = LUT_AW_DEF,
    parameter int BITSIZE = BITSIZE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LUT_AW-1:0]  addr,
    output logic [BITSIZE-1:0] data
);

    // Half-LSB phase offset keeps every entry positive and the wave symmetric.
    function automatic logic [BITSIZE-1:0] rom_entry(input int idx);
        real amp;
        real ang;
        amp = real'((2 ** (BITSIZE - 1)) - 1);
        ang = 1.5707963267948966 * (real'(idx) + 0.5) / real'(2 ** LUT_AW);
        return BITSIZE'($rtoi(amp * $sin(ang) + 0.5));
    endfunction

    logic [BITSIZE-1:0] w_table [2 ** LUT_AW];

    for (genvar i = 0; i < 2 ** LUT_AW; i++) begin : g_rom
        assign w_table[i] = rom_entry(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
        end else begin
            data <= w_table[addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/tone_nco.sv
// ============================================================================
// Module      : tone_nco
// Description : LRCLK-paced DDS sine source for the I2S transmitter.
//               Optional linear frequency sweep: define TONE_NCO_SWEEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_nco
    import tone_pkg::*;
#(
    parameter int BITSIZE = BITSIZE_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int LUT_AW  = LUT_AW_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      lrclk,
    input  logic                      en,
    input  logic [PHASE_W-1:0]        inc,
    input  logic                      phase_clr,
    input  logic [3:0]                atten,
`ifdef TONE_NCO_SWEEP_EN
    input  logic signed [PHASE_W-1:0] sweep_step,
    input  logic [PHASE_W-1:0]        sweep_lim,
`endif
    output logic [BITSIZE-1:0]        left_chan,
    output logic [BITSIZE-1:0]        right_chan,
    output logic                      sample_valid
);

    logic [2:0]                r_lr_sync;
    logic                      w_tick;
    logic [PHASE_W-1:0]        w_inc;
    logic [PHASE_W-1:0]        r_phase;
    logic                      r_clr_pend;
    logic                      r_v0, r_v1, r_v2;
    logic                      r_mute0, r_mute1, r_mute2;
    logic                      r_neg1, r_neg2;
    logic [LUT_AW-1:0]         r_addr;
    logic [BITSIZE-1:0]        w_rom_data;
    quadrant_t                 w_quad;
    logic [LUT_AW-1:0]         w_frac;
    logic signed [BITSIZE-1:0] w_signed;
    logic signed [BITSIZE-1:0] w_shifted;

    // Bits [1:0] synchronise, bit [2] is the previous level for edge detect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lr_sync <= '0;
        end else begin
            r_lr_sync <= {r_lr_sync[1:0], lrclk};
        end
    end

    assign w_tick = r_lr_sync[1] & ~r_lr_sync[2];

`ifdef TONE_NCO_SWEEP_EN
    logic [PHASE_W-1:0]      r_inc_eff;
    logic                    r_inc_load;
    logic signed [PHASE_W+1:0] w_sweep_sum;

    assign w_sweep_sum = $signed({2'b00, r_inc_eff})
                       + $signed({{2{sweep_step[PHASE_W-1]}}, sweep_step});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inc_eff  <= '0;
            r_inc_load <= 1'b1;
        end else if (r_inc_load || phase_clr) begin
            r_inc_eff  <= inc;
            r_inc_load <= 1'b0;
        end else if (w_tick && en) begin
            if (w_sweep_sum > $signed({2'b00, sweep_lim}) ||
                w_sweep_sum < $signed({2'b00, inc})) begin
                r_inc_eff <= inc;
            end else begin
                r_inc_eff <= w_sweep_sum[PHASE_W-1:0];
            end
        end
    end

    assign w_inc = r_inc_eff;
`else
    assign w_inc = inc;
`endif

    // S0: phase accumulator; a clear (pending or coincident) beats advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase    <= '0;
            r_clr_pend <= 1'b0;
            r_v0       <= 1'b0;
            r_mute0    <= 1'b0;
        end else if (w_tick) begin
            r_v0    <= 1'b1;
            r_mute0 <= ~en;
            if (r_clr_pend || phase_clr) begin
                r_phase    <= '0;
                r_clr_pend <= 1'b0;
            end else if (en) begin
                r_phase <= r_phase + w_inc;
            end
        end else begin
            r_v0 <= 1'b0;
            if (phase_clr) begin
                r_clr_pend <= 1'b1;
            end
        end
    end

    assign w_quad = quadrant_t'(r_phase[PHASE_W-1 -: 2]);
    assign w_frac = r_phase[PHASE_W-3 -: LUT_AW];

    // S1: fold the phase onto the quarter wave.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1    <= 1'b0;
            r_addr  <= '0;
            r_neg1  <= 1'b0;
            r_mute1 <= 1'b0;
        end else begin
            r_v1    <= r_v0;
            r_addr  <= (w_quad == Q1 || w_quad == Q3) ? ~w_frac : w_frac;
            r_neg1  <= (w_quad == Q2 || w_quad == Q3);
            r_mute1 <= r_mute0;
        end
    end

    // S2: registered table read, sideband delayed alongside.
    sine_quarter_rom #(
        .LUT_AW  (LUT_AW),
        .BITSIZE (BITSIZE)
    ) u_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (r_addr),
        .data (w_rom_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v2    <= 1'b0;
            r_neg2  <= 1'b0;
            r_mute2 <= 1'b0;
        end else begin
            r_v2    <= r_v1;
            r_neg2  <= r_neg1;
            r_mute2 <= r_mute1;
        end
    end

    assign w_signed  = r_neg2 ? -$signed(w_rom_data) : $signed(w_rom_data);
    assign w_shifted = w_signed >>> atten;

    // S3: sign, attenuate, mute; outputs hold between samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_chan    <= '0;
            right_chan   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= r_v2;
            if (r_v2) begin
                left_chan  <= r_mute2 ? '0 : w_shifted;
                right_chan <= r_mute2 ? '0 : w_shifted;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tone_nco.sv
// ============================================================================
// Module      : tb_tone_nco
// Description : Table-driven scoreboard bench for tone_nco.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tone_nco;
    import tone_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lrclk;
    logic        en;
    logic [23:0] inc;
    logic        phase_clr;
    logic [3:0]  atten;
    logic [15:0] left_chan;
    logic [15:0] right_chan;
    logic        sample_valid;

    tone_nco dut (
        .clk          (clk),
        .rst          (rst),
        .lrclk        (lrclk),
        .en           (en),
        .inc          (inc),
        .phase_clr    (phase_clr),
        .atten        (atten),
        .left_chan    (left_chan),
        .right_chan   (right_chan),
        .sample_valid (sample_valid)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        en;
        logic [23:0] inc;
        logic [3:0]  atten;
        int          clr;   // 0 none, 1 with the tick, 2 between ticks
        int          want;
    } vec_t;

    typedef struct {
        int want;
        int due;
    } sb_t;

    vec_t vecs[24];
    sb_t  sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_valid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int s16(input logic [15:0] x);
        return int'($signed(x));
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (sample_valid) begin
            sb_t e;
            n_valid++;
            if (sbq.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("left_sample", s16(left_chan), e.want);
                check("right_sample", s16(right_chan), e.want);
                check("latency_cycle", cyc, e.due);
            end
        end
    end

    // tick lands two clk edges after the lrclk rise seen at this negedge
    task automatic run_tick(input int want, input bit push, input bit clr_tick);
        @(negedge clk);
        lrclk = 1'b1;
        if (push) sbq.push_back('{want, cyc + 2 + TICK_LAT});
        repeat (2) @(negedge clk);
        if (clr_tick) phase_clr = 1'b1;
        @(negedge clk);
        phase_clr = 1'b0;
        repeat (3) @(negedge clk);
        lrclk = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        vecs[0]  = '{1'b1, 24'h400000, 4'd0,  0, 32767};
        vecs[1]  = '{1'b1, 24'h400000, 4'd0,  0, -101};
        vecs[2]  = '{1'b1, 24'h400000, 4'd0,  0, -32767};
        vecs[3]  = '{1'b1, 24'h400000, 4'd0,  0, 101};
        vecs[4]  = '{1'b1, 24'h400000, 4'd0,  0, 32767};
        vecs[5]  = '{1'b1, 24'h400000, 4'd3,  0, -13};
        vecs[6]  = '{1'b1, 24'h400000, 4'd3,  0, -4096};
        vecs[7]  = '{1'b1, 24'h400000, 4'd3,  0, 12};
        vecs[8]  = '{1'b1, 24'h400000, 4'd3,  0, 4095};
        vecs[9]  = '{1'b0, 24'h400000, 4'd3,  0, 0};
        vecs[10] = '{1'b0, 24'h400000, 4'd0,  0, 0};
        vecs[11] = '{1'b1, 24'h400000, 4'd0,  0, -101};
        vecs[12] = '{1'b1, 24'h400000, 4'd1,  0, -16384};
        vecs[13] = '{1'b1, 24'h400000, 4'd15, 0, 0};
        vecs[14] = '{1'b1, 24'h400000, 4'd15, 0, 0};
        vecs[15] = '{1'b1, 24'h400000, 4'd15, 0, -1};
        vecs[16] = '{1'b1, 24'h400000, 4'd0,  1, 101};
        vecs[17] = '{1'b1, 24'h400000, 4'd0,  0, 32767};
        vecs[18] = '{1'b1, 24'h400000, 4'd0,  2, 101};
        vecs[19] = '{1'b1, 24'hC00000, 4'd0,  0, -32767};
        vecs[20] = '{1'b1, 24'hC00000, 4'd0,  0, -101};
        vecs[21] = '{1'b1, 24'h000000, 4'd0,  0, -101};
        vecs[22] = '{1'b0, 24'h400000, 4'd0,  1, 0};
        vecs[23] = '{1'b1, 24'h400000, 4'd0,  0, 32767};

        rst = 1'b0; lrclk = 1'b0; en = 1'b1; inc = 24'h400000;
        phase_clr = 1'b0; atten = 4'd0;

        repeat (3) @(negedge clk);
        check("reset_left", s16(left_chan), 0);
        check("reset_right", s16(right_chan), 0);
        check("reset_valid", int'(sample_valid), 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_left", s16(left_chan), 0);
        check("idle_valid_count", n_valid, 0);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            en = vecs[i].en; inc = vecs[i].inc; atten = vecs[i].atten;
            if (vecs[i].clr == 2) begin
                @(negedge clk); phase_clr = 1'b1;
                @(negedge clk); phase_clr = 1'b0;
            end
            run_tick(vecs[i].want, 1'b1, vecs[i].clr == 1);
        end

        // reset lands while the tick is inside the pipeline
        en = 1'b1; inc = 24'h400000; atten = 4'd0;
        nv = n_valid;
        @(negedge clk);
        lrclk = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_left", s16(left_chan), 0);
        check("midrst_right", s16(right_chan), 0);
        repeat (3) @(negedge clk);
        lrclk = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_valid", n_valid - nv, 0);
        check("midrst_hold_left", s16(left_chan), 0);
        run_tick(32767, 1'b1, 1'b0);

        for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clk);
        check("scoreboard_drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
